// File: rtl/fabric_boot_ctrl.sv
// rtl/fabric_boot_ctrl.sv - boot sequencer: source select, word forwarding, source-0 retries
// Optional LOAD inactivity timeout is compiled in with FABRIC_BOOT_TIMEOUT_EN.
module fabric_boot_ctrl #(
  parameter int          NUM_SRC        = 2,
  parameter int          DATA_W         = 32,
  parameter int          SLOT_W         = 4,
  parameter logic [31:0] LEN_WORDS      = 32'hEA2,
  parameter int          MAX_RETRIES    = 3,
  parameter int          TIMEOUT_CYCLES = 65536,
  localparam int         MSW            = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [MSW-1:0]            mode_i,
  input  logic [SLOT_W-1:0]         slot_i,
  input  logic                      reboot_i,
  input  logic [NUM_SRC-1:0]        src_valid_i,
  input  logic [NUM_SRC*DATA_W-1:0] src_data_i,
  input  logic [NUM_SRC-1:0]        src_busy_i,
  input  logic                      cfg_busy_i,
  input  logic                      configured_i,
  output logic                      ctrl_start_o,
  output logic [SLOT_W-1:0]         ctrl_slot_o,
  output logic [NUM_SRC-1:0]        src_en_o,
  output logic                      bitstream_valid_o,
  output logic [DATA_W-1:0]         bitstream_data_o,
  output logic                      boot_busy_o,
  output logic                      boot_done_o,
  output logic                      boot_error_o,
  output logic [1:0]                retry_cnt_o,
  output logic [31:0]               word_cnt_o
);

  typedef enum logic [2:0] {IDLE, START, LOAD, DRAIN, DONE, ERROR} state_t;

  state_t             state, nxt;
  logic [MSW-1:0]     mode_s1, mode_s2, sel, sel_n;
  logic [1:0]         sync_fill;
  logic               autoboot, busy_q;
  logic               sel_valid, accept, last_word, abort, retry, boot_req;
  logic [DATA_W-1:0]  sel_data;
  logic [NUM_SRC-1:0] sel_onehot;
  logic               unused_busy;
`ifdef FABRIC_BOOT_TIMEOUT_EN
  logic [31:0]        idle_cnt;
`endif

  assign unused_busy = ^src_busy_i;

  always_comb begin
    sel_valid  = 1'b0;
    sel_data   = '0;
    sel_onehot = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      sel_onehot[k] = (int'(sel) == k);
      if (int'(sel) == k) begin
        sel_valid = src_valid_i[k];
        sel_data  = src_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    accept    = (state == LOAD) && sel_valid;
    last_word = accept && (word_cnt_o + 32'd1 == LEN_WORDS);
    abort     = (state == LOAD) && !last_word &&
                ((sel == '0) && busy_q && !src_busy_i[0]);
`ifdef FABRIC_BOOT_TIMEOUT_EN
    if ((state == LOAD) && !sel_valid && (idle_cnt == 32'(TIMEOUT_CYCLES - 1)))
      abort = 1'b1;
`endif
    retry    = abort && (sel == '0) && (int'(retry_cnt_o) < MAX_RETRIES);
    // Autoboot waits until the mode synchronizer holds a real sample.
    boot_req = (state inside {IDLE, DONE, ERROR}) &&
               (reboot_i || ((state == IDLE) && autoboot && (sync_fill == 2'd2)));
    sel_n    = boot_req ? mode_s2 : sel;
    nxt      = state;
    case (state)
      IDLE, DONE, ERROR: if (boot_req) nxt = START;
      START:             nxt = (int'(sel) >= NUM_SRC) ? ERROR : LOAD;
      LOAD: begin
        if (last_word)  nxt = DRAIN;
        else if (retry) nxt = START;
        else if (abort) nxt = ERROR;
      end
      DRAIN:             if (!cfg_busy_i && configured_i) nxt = DONE;
      default:           nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state             <= IDLE;
      mode_s1           <= '0;
      mode_s2           <= '0;
      sel               <= '0;
      sync_fill         <= '0;
      autoboot          <= 1'b1;
      busy_q            <= 1'b0;
      ctrl_start_o      <= 1'b0;
      ctrl_slot_o       <= '0;
      src_en_o          <= '0;
      bitstream_valid_o <= 1'b0;
      bitstream_data_o  <= '0;
      boot_busy_o       <= 1'b0;
      boot_done_o       <= 1'b0;
      boot_error_o      <= 1'b0;
      retry_cnt_o       <= '0;
      word_cnt_o        <= '0;
`ifdef FABRIC_BOOT_TIMEOUT_EN
      idle_cnt          <= '0;
`endif
    end else begin
      mode_s1 <= mode_i;
      mode_s2 <= mode_s1;
      if (sync_fill != 2'd2) sync_fill <= sync_fill + 2'd1;
      busy_q  <= src_busy_i[0];
      state   <= nxt;
      sel     <= sel_n;
      bitstream_valid_o <= accept;
      if (accept) begin
        bitstream_data_o <= sel_data;
        word_cnt_o       <= word_cnt_o + 32'd1;
      end
      if (boot_req) begin
        ctrl_slot_o <= slot_i;
        word_cnt_o  <= '0;
        retry_cnt_o <= '0;
        autoboot    <= 1'b0;
      end
      // A retry keeps both the latched source and slot.
      if (retry) begin
        retry_cnt_o <= retry_cnt_o + 2'd1;
        word_cnt_o  <= '0;
      end
      ctrl_start_o <= (nxt == START) && (sel_n == '0);
      src_en_o     <= (nxt == LOAD || nxt == DRAIN) ? sel_onehot : '0;
      boot_busy_o  <= (nxt inside {START, LOAD, DRAIN});
      boot_done_o  <= (nxt == DONE);
      boot_error_o <= (nxt == ERROR);
`ifdef FABRIC_BOOT_TIMEOUT_EN
      if (accept || state != LOAD) idle_cnt <= '0;
      else                         idle_cnt <= idle_cnt + 32'd1;
`endif
    end
  end

endmodule

// File: tb/tb_fabric_boot_ctrl.sv
// tb/tb_fabric_boot_ctrl.sv - randomized self-checking bench for fabric_boot_ctrl
// Honours FABRIC_BOOT_TIMEOUT_EN (timeout shortened to 16 cycles).
module tb_fabric_boot_ctrl;
  localparam int          NS  = 2;
  localparam int          DW  = 32;
  localparam int          SW  = 4;
  localparam logic [31:0] LEN = 32'hEA2;
`ifdef FABRIC_BOOT_TIMEOUT_EN
  localparam int          TO  = 16;
`else
  localparam int          TO  = 65536;
`endif

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic [0:0]       mode_i = '0;
  logic [SW-1:0]    slot_i = '0;
  logic             reboot_i = 1'b0;
  logic [NS-1:0]    src_valid_i = '0;
  logic [NS*DW-1:0] src_data_i = '0;
  logic [NS-1:0]    src_busy_i = '0;
  logic             cfg_busy_i = 1'b0;
  logic             configured_i = 1'b0;
  logic             ctrl_start_o, bitstream_valid_o, boot_busy_o, boot_done_o, boot_error_o;
  logic [SW-1:0]    ctrl_slot_o;
  logic [NS-1:0]    src_en_o;
  logic [DW-1:0]    bitstream_data_o;
  logic [1:0]       retry_cnt_o;
  logic [31:0]      word_cnt_o;

  fabric_boot_ctrl #(
    .NUM_SRC(NS), .DATA_W(DW), .SLOT_W(SW), .LEN_WORDS(LEN),
    .MAX_RETRIES(3), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .mode_i(mode_i), .slot_i(slot_i), .reboot_i(reboot_i),
    .src_valid_i(src_valid_i), .src_data_i(src_data_i), .src_busy_i(src_busy_i),
    .cfg_busy_i(cfg_busy_i), .configured_i(configured_i),
    .ctrl_start_o(ctrl_start_o), .ctrl_slot_o(ctrl_slot_o), .src_en_o(src_en_o),
    .bitstream_valid_o(bitstream_valid_o), .bitstream_data_o(bitstream_data_o),
    .boot_busy_o(boot_busy_o), .boot_done_o(boot_done_o), .boot_error_o(boot_error_o),
    .retry_cnt_o(retry_cnt_o), .word_cnt_o(word_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] data; int at; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int   checks = 0, errors = 0;
  int   model_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Forwarded words must match the model's queue in value and arrive one cycle after being offered.
  always @(negedge clk) begin
    if (!rst_i && bitstream_valid_o) begin
      if (exp_q.size() == 0) check("extra_word", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("word_data", bitstream_data_o, e.data);
        check("word_cycle", cyc, e.at);
      end
    end
  end

  task automatic noise(input int s);
    for (int k = 0; k < NS; k++) begin
      src_valid_i[k] = (k != s) ? 1'($urandom_range(0, 1)) : 1'b0;
      src_data_i[k*DW +: DW] = $urandom();
    end
  endtask

  // Offer n words on source s; the model forwards only the first LEN of a boot attempt.
  task automatic stream(input int s, input int n, input bit flip_mode);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        noise(s);
        tick();
      end
      noise(s);
      w = $urandom();
      src_valid_i[s] = 1'b1;
      src_data_i[s*DW +: DW] = w;
      if (model_cnt < int'(LEN)) begin
        exp_q.push_back('{w, cyc + 1});
        model_cnt++;
      end
      if (flip_mode && i == n / 2) mode_i = ~mode_i;
      tick();
    end
    src_valid_i = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, ctrl_start_o, 0);
    check({tag, "_slot"}, ctrl_slot_o, 0);
    check({tag, "_en"}, src_en_o, 0);
    check({tag, "_valid"}, bitstream_valid_o, 0);
    check({tag, "_status"}, {boot_busy_o, boot_done_o, boot_error_o}, 0);
    check({tag, "_retry"}, retry_cnt_o, 0);
    check({tag, "_wcnt"}, word_cnt_o, 0);
  endtask

  task automatic do_reboot();
    reboot_i = 1'b1;
    tick();
    reboot_i = 1'b0;
    model_cnt = 0;
  endtask

  initial begin
    int c0, pcyc, pulses, lcyc, ecyc;
    mode_i = 1'b0;
    slot_i = 4'd3;
    repeat (3) tick();
    check_all_zero("reset");

    // Autoboot from source 0 after the mode synchronizer fills.
    rst_i = 1'b0;
    c0 = cyc;
    pcyc = -1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ctrl_start_o) begin
        pulses++;
        if (pcyc < 0) begin
          pcyc = cyc;
          check("autoboot_slot", ctrl_slot_o, 3);
          check("autoboot_busy", boot_busy_o, 1);
        end
      end
      if (i == 3) begin
        check("load_en_src0", src_en_o, 2'b01);
        src_busy_i[0] = 1'b1;
      end
    end
    check("autoboot_pulse_cycle", pcyc, c0 + 3);
    check("autoboot_pulse_count", pulses, 1);
    model_cnt = 0;
    stream(0, int'(LEN), 1'b0);
    src_busy_i[0] = 1'b0;
    repeat (2) tick();
    check("src0_queue_drained", exp_q.size(), 0);
    check("src0_word_cnt", word_cnt_o, LEN);
    check("drain_busy", {boot_busy_o, boot_done_o}, 2'b10);
    cfg_busy_i = 1'b1;
    configured_i = 1'b1;
    tick();
    tick();
    check("drain_wait_cfg_busy", boot_done_o, 0);
    cfg_busy_i = 1'b0;
    tick();
    tick();
    check("done_status", {boot_busy_o, boot_done_o, boot_error_o}, 3'b010);
    check("done_en", src_en_o, 0);

    // Passive source 1, overflow by 5 words, mode flipped mid-load.
    mode_i = 1'b1;
    slot_i = 4'd5;
    configured_i = 1'b0;
    repeat (3) tick();
    do_reboot();
    check("src1_no_pulse", ctrl_start_o, 0);
    check("src1_slot", ctrl_slot_o, 5);
    tick();
    check("load_en_src1", src_en_o, 2'b10);
    stream(1, int'(LEN) + 5, 1'b1);
    repeat (2) tick();
    check("src1_queue_drained", exp_q.size(), 0);
    check("src1_word_cnt", word_cnt_o, LEN);
    check("sel_held", src_en_o, 2'b10);
    configured_i = 1'b1;
    tick();
    tick();
    check("src1_done", boot_done_o, 1);

    // Source 0 abandons the read four times: three retries then error.
    slot_i = 4'd7;
    repeat (3) tick();
    do_reboot();
    check("retry_first_pulse", ctrl_start_o, 1);
    slot_i = 4'd2;
    for (int k = 1; k <= 4; k++) begin
      tick();
      src_busy_i[0] = 1'b1;
      tick();
      model_cnt = 0;
      stream(0, 10, 1'b0);
      check("retry_word_cnt", word_cnt_o, 10);
      src_busy_i[0] = 1'b0;
      tick();
      if (k <= 3) begin
        check("retry_cnt", retry_cnt_o, k);
        check("retry_pulse", ctrl_start_o, 1);
        check("retry_slot_kept", ctrl_slot_o, 7);
        check("retry_word_clr", word_cnt_o, 0);
      end else begin
        check("retry_exhausted_err", {boot_busy_o, boot_error_o}, 2'b01);
        check("retry_exhausted_cnt", retry_cnt_o, 3);
      end
    end
    do_reboot();
    check("reboot_retry_clr", retry_cnt_o, 0);
    check("reboot_pulse", ctrl_start_o, 1);
    check("reboot_err_clr", boot_error_o, 0);

    // Reset in the middle of a load.
    tick();
    src_busy_i[0] = 1'b1;
    tick();
    stream(0, 20, 1'b0);
    rst_i = 1'b1;
    src_busy_i[0] = 1'b0;
    tick();
    exp_q.delete();
    check_all_zero("midload_reset");

    // Fresh release with source 1 and no words offered.
    mode_i = 1'b1;
    tick();
    rst_i = 1'b0;
    c0 = cyc;
    lcyc = -1;
    for (int i = 0; i < 10 && lcyc < 0; i++) begin
      tick();
      if (src_en_o != 0) lcyc = cyc;
    end
    check("rerelease_load_cycle", lcyc, c0 + 4);
`ifdef FABRIC_BOOT_TIMEOUT_EN
    ecyc = -1;
    for (int i = 0; i < TO + 8 && ecyc < 0; i++) begin
      tick();
      if (boot_error_o) ecyc = cyc;
    end
    check("timeout_cycles", ecyc - lcyc, TO);
    repeat (5) tick();
    check("no_second_autoboot", boot_error_o, 1);
`else
    ecyc = 0;
    repeat (200) tick();
    check("no_timeout_err", {boot_busy_o, boot_error_o, ecyc[0]}, 3'b100);
    check("no_timeout_en", src_en_o, 2'b10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
